// File: rtl/bullet_hit_detector.sv
// Time-multiplexed collision scanner: player bullets vs enemies, then enemy bullets vs player.
// Optional macro BULLET_HIT_PLAYER_INVULN_EN removes the enemy-bullet scan and ties o_PlayerHit low.
module bullet_hit_detector #(
  parameter int MAX_ENEMY         = 15,
  parameter int MAX_ENEMY_BULLET  = 30,
  parameter int MAX_PLAYER_BULLET = 16,
  parameter int BULLET_W          = 6,
  parameter int BULLET_H          = 20,
  parameter int ENEMY_W           = 36,
  parameter int ENEMY_H           = 36,
  parameter int PLAYER_W          = 36,
  parameter int PLAYER_H          = 36,
  parameter int SCORE_PER_KILL    = 10
) (
  input  logic                            i_Clk,
  input  logic                            i_Rst,
  input  logic                            i_Start,
  input  logic [19*MAX_PLAYER_BULLET-1:0] i_PlayerBulletPos,
  input  logic [MAX_PLAYER_BULLET-1:0]    i_PlayerBulletValid,
  input  logic [19*MAX_ENEMY-1:0]         i_EnemyPos,
  input  logic [MAX_ENEMY-1:0]            i_EnemyAlive,
  input  logic [19*MAX_ENEMY_BULLET-1:0]  i_EnemyBulletPos,
  input  logic [MAX_ENEMY_BULLET-1:0]     i_EnemyBulletValid,
  input  logic [18:0]                     i_PlayerPos,
  output logic [MAX_ENEMY-1:0]            o_EnemyKill,
  output logic [MAX_PLAYER_BULLET-1:0]    o_PlayerBulletHit,
  output logic                            o_PlayerHit,
  output logic [11:0]                     o_Score,
  output logic                            o_Busy,
  output logic                            o_Done
);

  localparam int PB_W  = $clog2(MAX_PLAYER_BULLET);
  localparam int EN_W  = $clog2(MAX_ENEMY);
  localparam int CNT_W = $clog2(MAX_ENEMY + 1);
  localparam logic [PB_W-1:0] PB_LAST = PB_W'(MAX_PLAYER_BULLET - 1);
  localparam logic [EN_W-1:0] EN_LAST = EN_W'(MAX_ENEMY - 1);
  localparam logic [18:0]     NONE_POS = 19'h7FFFF;

`ifdef BULLET_HIT_PLAYER_INVULN_EN
  typedef enum logic [1:0] {IDLE, SCAN_PB, REPORT} state_t;
`else
  localparam int EB_W = $clog2(MAX_ENEMY_BULLET);
  localparam logic [EB_W-1:0] EB_LAST = EB_W'(MAX_ENEMY_BULLET - 1);
  typedef enum logic [1:0] {IDLE, SCAN_PB, SCAN_EB, REPORT} state_t;
`endif

  state_t r_State;

  logic [18:0]                  r_PbPos [MAX_PLAYER_BULLET];
  logic [MAX_PLAYER_BULLET-1:0] r_PbValid;
  logic [18:0]                  r_EnPos [MAX_ENEMY];
  logic [MAX_ENEMY-1:0]         r_EnAlive;
  logic [PB_W-1:0]              r_B;
  logic [EN_W-1:0]              r_E;
  logic [MAX_ENEMY-1:0]         r_KillMask;
  logic [MAX_PLAYER_BULLET-1:0] r_HitMask;

`ifndef BULLET_HIT_PLAYER_INVULN_EN
  logic [18:0]                  r_EbPos [MAX_ENEMY_BULLET];
  logic [MAX_ENEMY_BULLET-1:0]  r_EbValid;
  logic [18:0]                  r_PlayerPos;
  logic [EB_W-1:0]              r_K;
  logic                         r_PlayerHitFlag;
`endif

  // Strict box overlap on top-left corners; 11 bits leave headroom so x+w never wraps.
  function automatic logic fOverlap(input logic [18:0] a, input int aw, input int ah,
                                    input logic [18:0] b, input int bw, input int bh);
    logic [10:0] ax, ay, bx, by;
    ax = {1'b0, a[18:9]};
    ay = {2'b00, a[8:0]};
    bx = {1'b0, b[18:9]};
    by = {2'b00, b[8:0]};
    return (ax < bx + 11'(bw)) && (bx < ax + 11'(aw)) &&
           (ay < by + 11'(bh)) && (by < ay + 11'(ah));
  endfunction

  logic [18:0] w_PbPos;
  logic [18:0] w_EnPos;
  logic        w_PairQual;
  logic        w_PairHit;

  assign w_PbPos    = r_PbPos[r_B];
  assign w_EnPos    = r_EnPos[r_E];
  assign w_PairQual = r_PbValid[r_B] && (w_PbPos != NONE_POS) && !r_HitMask[r_B] &&
                      r_EnAlive[r_E] && !r_KillMask[r_E];
  assign w_PairHit  = w_PairQual &&
                      fOverlap(w_PbPos, BULLET_W, BULLET_H, w_EnPos, ENEMY_W, ENEMY_H);

`ifndef BULLET_HIT_PLAYER_INVULN_EN
  logic [18:0] w_EbPos;
  logic        w_EbHit;

  assign w_EbPos = r_EbPos[r_K];
  assign w_EbHit = r_EbValid[r_K] && (w_EbPos != NONE_POS) &&
                   fOverlap(w_EbPos, BULLET_W, BULLET_H, r_PlayerPos, PLAYER_W, PLAYER_H);
`else
  assign o_PlayerHit = 1'b0;
`endif

  logic [CNT_W-1:0] w_KillCount;
  logic [31:0]      w_ScoreSum;
  logic [11:0]      w_ScoreNext;

  always_comb begin
    w_KillCount = '0;
    for (int i = 0; i < MAX_ENEMY; i++) begin
      w_KillCount = w_KillCount + CNT_W'(r_KillMask[i]);
    end
  end

  assign w_ScoreSum  = 32'(o_Score) + 32'(w_KillCount) * 32'(SCORE_PER_KILL);
  assign w_ScoreNext = (w_ScoreSum > 32'd4095) ? 12'hFFF : w_ScoreSum[11:0];

  // Single FSM: snapshot on start, walk every (bullet, enemy) pair, then every enemy bullet.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_State           <= IDLE;
      r_B               <= '0;
      r_E               <= '0;
      r_KillMask        <= '0;
      r_HitMask         <= '0;
      r_PbValid         <= '0;
      r_EnAlive         <= '0;
      o_EnemyKill       <= '0;
      o_PlayerBulletHit <= '0;
      o_Score           <= '0;
      o_Busy            <= 1'b0;
      o_Done            <= 1'b0;
      for (int i = 0; i < MAX_PLAYER_BULLET; i++) r_PbPos[i] <= '0;
      for (int i = 0; i < MAX_ENEMY; i++) r_EnPos[i] <= '0;
`ifndef BULLET_HIT_PLAYER_INVULN_EN
      r_K             <= '0;
      r_EbValid       <= '0;
      r_PlayerPos     <= '0;
      r_PlayerHitFlag <= 1'b0;
      o_PlayerHit     <= 1'b0;
      for (int i = 0; i < MAX_ENEMY_BULLET; i++) r_EbPos[i] <= '0;
`endif
    end else begin
      o_EnemyKill       <= '0;
      o_PlayerBulletHit <= '0;
      o_Done            <= 1'b0;
`ifndef BULLET_HIT_PLAYER_INVULN_EN
      o_PlayerHit       <= 1'b0;
`endif
      case (r_State)
        IDLE: begin
          if (i_Start) begin
            for (int i = 0; i < MAX_PLAYER_BULLET; i++) r_PbPos[i] <= i_PlayerBulletPos[i*19 +: 19];
            for (int i = 0; i < MAX_ENEMY; i++) r_EnPos[i] <= i_EnemyPos[i*19 +: 19];
            r_PbValid  <= i_PlayerBulletValid;
            r_EnAlive  <= i_EnemyAlive;
            r_KillMask <= '0;
            r_HitMask  <= '0;
            r_B        <= '0;
            r_E        <= '0;
`ifndef BULLET_HIT_PLAYER_INVULN_EN
            for (int i = 0; i < MAX_ENEMY_BULLET; i++) r_EbPos[i] <= i_EnemyBulletPos[i*19 +: 19];
            r_EbValid       <= i_EnemyBulletValid;
            r_PlayerPos     <= i_PlayerPos;
            r_PlayerHitFlag <= 1'b0;
            r_K             <= '0;
`endif
            o_Busy  <= 1'b1;
            r_State <= SCAN_PB;
          end
        end

        SCAN_PB: begin
          // Hit/kill flags gate later pairs, so the lowest index wins on both sides.
          if (w_PairHit) begin
            r_KillMask[r_E] <= 1'b1;
            r_HitMask[r_B]  <= 1'b1;
          end
          if (r_E == EN_LAST) begin
            r_E <= '0;
            if (r_B == PB_LAST) begin
              r_B <= '0;
`ifdef BULLET_HIT_PLAYER_INVULN_EN
              r_State <= REPORT;
`else
              r_State <= SCAN_EB;
`endif
            end else begin
              r_B <= r_B + 1'b1;
            end
          end else begin
            r_E <= r_E + 1'b1;
          end
        end

`ifndef BULLET_HIT_PLAYER_INVULN_EN
        SCAN_EB: begin
          if (w_EbHit) r_PlayerHitFlag <= 1'b1;
          if (r_K == EB_LAST) begin
            r_K     <= '0;
            r_State <= REPORT;
          end else begin
            r_K <= r_K + 1'b1;
          end
        end
`endif

        REPORT: begin
          o_EnemyKill       <= r_KillMask;
          o_PlayerBulletHit <= r_HitMask;
`ifndef BULLET_HIT_PLAYER_INVULN_EN
          o_PlayerHit       <= r_PlayerHitFlag;
`endif
          o_Done  <= 1'b1;
          o_Score <= w_ScoreNext;
          o_Busy  <= 1'b0;
          r_State <= IDLE;
        end

        default: r_State <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_hit_detector.sv
// Table-driven bench for bullet_hit_detector with a scoreboard of expected scan reports.
// A second instance with SCORE_PER_KILL=4000 exercises score saturation on the same stimulus.
module tb_bullet_hit_detector;

`ifdef BULLET_HIT_PLAYER_INVULN_EN
  localparam int  LAT    = 241;
  localparam bit  INVULN = 1'b1;
`else
  localparam int  LAT    = 271;
  localparam bit  INVULN = 1'b0;
`endif

  logic          i_Clk = 1'b0;
  logic          i_Rst;
  logic          i_Start;
  logic [303:0]  i_PlayerBulletPos;
  logic [15:0]   i_PlayerBulletValid;
  logic [284:0]  i_EnemyPos;
  logic [14:0]   i_EnemyAlive;
  logic [569:0]  i_EnemyBulletPos;
  logic [29:0]   i_EnemyBulletValid;
  logic [18:0]   i_PlayerPos;
  logic [14:0]   o_EnemyKill;
  logic [15:0]   o_PlayerBulletHit;
  logic          o_PlayerHit;
  logic [11:0]   o_Score;
  logic          o_Busy;
  logic          o_Done;
  logic [14:0]   satKill;
  logic [15:0]   satHit;
  logic          satPlayerHit;
  logic [11:0]   satScore;
  logic          satBusy;
  logic          satDone;

  bullet_hit_detector dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start),
    .i_PlayerBulletPos(i_PlayerBulletPos), .i_PlayerBulletValid(i_PlayerBulletValid),
    .i_EnemyPos(i_EnemyPos), .i_EnemyAlive(i_EnemyAlive),
    .i_EnemyBulletPos(i_EnemyBulletPos), .i_EnemyBulletValid(i_EnemyBulletValid),
    .i_PlayerPos(i_PlayerPos),
    .o_EnemyKill(o_EnemyKill), .o_PlayerBulletHit(o_PlayerBulletHit), .o_PlayerHit(o_PlayerHit),
    .o_Score(o_Score), .o_Busy(o_Busy), .o_Done(o_Done)
  );

  bullet_hit_detector #(.SCORE_PER_KILL(4000)) dutSat (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start),
    .i_PlayerBulletPos(i_PlayerBulletPos), .i_PlayerBulletValid(i_PlayerBulletValid),
    .i_EnemyPos(i_EnemyPos), .i_EnemyAlive(i_EnemyAlive),
    .i_EnemyBulletPos(i_EnemyBulletPos), .i_EnemyBulletValid(i_EnemyBulletValid),
    .i_PlayerPos(i_PlayerPos),
    .o_EnemyKill(satKill), .o_PlayerBulletHit(satHit), .o_PlayerHit(satPlayerHit),
    .o_Score(satScore), .o_Busy(satBusy), .o_Done(satDone)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [15:0] pbValid;
    logic [3:0]  pbIdxA;
    logic [18:0] pbPosA;
    logic [3:0]  pbIdxB;
    logic [18:0] pbPosB;
    logic [14:0] enAlive;
    logic [3:0]  enIdxA;
    logic [18:0] enPosA;
    logic [3:0]  enIdxB;
    logic [18:0] enPosB;
    logic [29:0] ebValid;
    logic [4:0]  ebIdx;
    logic [18:0] ebPos;
    logic [18:0] playerPos;
    logic [14:0] expKill;
    logic [15:0] expHit;
    logic        expPlayerHit;
  } vec_t;

  typedef struct {
    logic [14:0] kill;
    logic [15:0] hit;
    logic        playerHit;
    logic [11:0] score;
    logic [11:0] satScore;
    int          cycle;
  } exp_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];
  exp_t sb [$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;
  int   cycleCnt = 0;
  int   modelScore = 0;
  int   modelSatScore = 0;

  always @(posedge i_Clk) cycleCnt <= cycleCnt + 1;

  function automatic logic [18:0] P(input int x, input int y);
    return {10'(x), 9'(y)};
  endfunction

  function automatic int popcnt15(input logic [14:0] m);
    int n = 0;
    for (int i = 0; i < 15; i++) n += int'(m[i]);
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_PlayerBulletPos   = '0;
    i_EnemyPos          = '0;
    i_EnemyBulletPos    = '0;
    i_PlayerBulletPos[v.pbIdxA*19 +: 19] = v.pbPosA;
    i_PlayerBulletPos[v.pbIdxB*19 +: 19] = v.pbPosB;
    i_EnemyPos[v.enIdxA*19 +: 19]        = v.enPosA;
    i_EnemyPos[v.enIdxB*19 +: 19]        = v.enPosB;
    i_EnemyBulletPos[v.ebIdx*19 +: 19]   = v.ebPos;
    i_PlayerBulletValid = v.pbValid;
    i_EnemyAlive        = v.enAlive;
    i_EnemyBulletValid  = v.ebValid;
    i_PlayerPos         = v.playerPos;
  endtask

  task automatic pushExpected(input vec_t v);
    exp_t e;
    int kills;
    kills         = popcnt15(v.expKill);
    modelScore    = (modelScore + kills * 10 > 4095) ? 4095 : modelScore + kills * 10;
    modelSatScore = (modelSatScore + kills * 4000 > 4095) ? 4095 : modelSatScore + kills * 4000;
    e.kill      = v.expKill;
    e.hit       = v.expHit;
    e.playerHit = v.expPlayerHit & ~INVULN;
    e.score     = 12'(modelScore);
    e.satScore  = 12'(modelSatScore);
    e.cycle     = cycleCnt + 1 + LAT;
    sb.push_back(e);
  endtask

  task automatic pulseStart(input bit doPush, input vec_t v);
    @(negedge i_Clk);
    i_Start = 1'b1;
    if (doPush) pushExpected(v);
    @(negedge i_Clk);
    i_Start = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int c = 0; c < 400; c++) begin
      @(negedge i_Clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: o_Done not seen within 400 cycles", name);
      sb.delete();
    end
  endtask

  task automatic checkIdle(input string name);
    @(negedge i_Clk);
    #1;
    checkOutput({name, ".killAfter"}, 32'(o_EnemyKill), 32'd0);
    checkOutput({name, ".hitAfter"}, 32'(o_PlayerBulletHit), 32'd0);
    checkOutput({name, ".playerHitAfter"}, 32'(o_PlayerHit), 32'd0);
    checkOutput({name, ".doneAfter"}, 32'(o_Done), 32'd0);
    checkOutput({name, ".busyAfter"}, 32'(o_Busy), 32'd0);
  endtask

  task automatic runVector(input int idx);
    string name;
    name = $sformatf("vec%0d", idx);
    applyStimulus(vecs[idx]);
    pulseStart(1'b1, vecs[idx]);
    #1;
    checkOutput({name, ".busy"}, 32'(o_Busy), 32'd1);
    waitDrain(name);
    checkIdle(name);
  endtask

  // Scoreboard consumer: every o_Done pops one expected report.
  always @(negedge i_Clk) begin
    if (i_Rst === 1'b1 && o_Done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone: got o_Done=1 at cycle %0d, expected no report", cycleCnt);
      end else begin
        monExp = sb.pop_front();
        checkOutput("enemyKill", 32'(o_EnemyKill), 32'(monExp.kill));
        checkOutput("bulletHit", 32'(o_PlayerBulletHit), 32'(monExp.hit));
        checkOutput("playerHit", 32'(o_PlayerHit), 32'(monExp.playerHit));
        checkOutput("score", 32'(o_Score), 32'(monExp.score));
        checkOutput("satScore", 32'(satScore), 32'(monExp.satScore));
        checkOutput("busyAtDone", 32'(o_Busy), 32'd0);
        checkOutput("doneCycle", 32'(cycleCnt), 32'(monExp.cycle));
      end
    end
  end

  initial begin
    vec_t dummy;
    vecs[0]  = '{16'h0001, 4'd0, P(302,110), 4'd0, P(302,110), 15'h0080, 4'd7, P(302,108), 4'd7, P(302,108),
                 30'h0, 5'd0, P(0,0), P(0,0), 15'h0080, 16'h0001, 1'b0};
    vecs[1]  = '{16'h0024, 4'd2, P(100,200), 4'd5, P(104,210), 15'h0008, 4'd3, P(100,200), 4'd3, P(100,200),
                 30'h0, 5'd0, P(0,0), P(600,400), 15'h0008, 16'h0004, 1'b0};
    vecs[2]  = '{16'h0001, 4'd0, P(338,110), 4'd0, P(338,110), 15'h0080, 4'd7, P(302,108), 4'd7, P(302,108),
                 30'h0, 5'd0, P(0,0), P(600,400), 15'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{16'h0000, 4'd0, P(302,110), 4'd0, P(302,110), 15'h0080, 4'd7, P(302,108), 4'd7, P(302,108),
                 30'h0, 5'd0, P(0,0), P(600,400), 15'h0000, 16'h0000, 1'b0};
    vecs[4]  = '{16'h0001, 4'd0, 19'h7FFFF, 4'd0, 19'h7FFFF, 15'h0001, 4'd0, P(1000,490), 4'd0, P(1000,490),
                 30'h0, 5'd0, P(0,0), P(600,400), 15'h0000, 16'h0000, 1'b0};
    vecs[5]  = '{16'h0001, 4'd0, P(302,110), 4'd0, P(302,110), 15'h0000, 4'd7, P(302,108), 4'd7, P(302,108),
                 30'h0, 5'd0, P(0,0), P(600,400), 15'h0000, 16'h0000, 1'b0};
    vecs[6]  = '{16'h0000, 4'd0, P(0,0), 4'd0, P(0,0), 15'h0000, 4'd0, P(0,0), 4'd0, P(0,0),
                 30'h0000_0020, 5'd5, P(310,380), P(302,372), 15'h0000, 16'h0000, 1'b1};
    vecs[7]  = '{16'h0003, 4'd0, P(302,110), 4'd1, P(50,50), 15'h0084, 4'd7, P(302,108), 4'd2, P(48,40),
                 30'h0, 5'd0, P(0,0), P(600,400), 15'h0084, 16'h0003, 1'b0};
    vecs[8]  = '{16'h0001, 4'd0, P(200,200), 4'd0, P(200,200), 15'h0210, 4'd4, P(200,200), 4'd9, P(200,200),
                 30'h0, 5'd0, P(0,0), P(600,400), 15'h0010, 16'h0001, 1'b0};
    vecs[9]  = '{16'h8000, 4'd15, P(400,300), 4'd15, P(400,300), 15'h4000, 4'd14, P(400,300), 4'd14, P(400,300),
                 30'h0, 5'd0, P(0,0), P(600,400), 15'h4000, 16'h8000, 1'b0};
    vecs[10] = '{16'h0000, 4'd0, P(0,0), 4'd0, P(0,0), 15'h0000, 4'd0, P(0,0), 4'd0, P(0,0),
                 30'h2000_0000, 5'd29, P(310,380), P(302,372), 15'h0000, 16'h0000, 1'b1};
    vecs[11] = '{16'h0000, 4'd0, P(0,0), 4'd0, P(0,0), 15'h0000, 4'd0, P(0,0), 4'd0, P(0,0),
                 30'h0000_0008, 5'd3, 19'h7FFFF, P(1000,500), 15'h0000, 16'h0000, 1'b0};

    i_Rst   = 1'b0;
    i_Start = 1'b0;
    applyStimulus(vecs[5]);
    repeat (3) @(negedge i_Clk);
    #1;
    checkOutput("reset.kill", 32'(o_EnemyKill), 32'd0);
    checkOutput("reset.hit", 32'(o_PlayerBulletHit), 32'd0);
    checkOutput("reset.playerHit", 32'(o_PlayerHit), 32'd0);
    checkOutput("reset.score", 32'(o_Score), 32'd0);
    checkOutput("reset.busy", 32'(o_Busy), 32'd0);
    checkOutput("reset.done", 32'(o_Done), 32'd0);
    @(negedge i_Clk);
    i_Rst = 1'b1;

    for (int i = 0; i < NVEC; i++) runVector(i);

    // Restart attempts mid-scan and during the report cycle must both be ignored.
    applyStimulus(vecs[0]);
    pulseStart(1'b1, vecs[0]);
    repeat (49) @(negedge i_Clk);
    i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    #1;
    checkOutput("ignore.busyMid", 32'(o_Busy), 32'd1);
    repeat (LAT - 51) @(negedge i_Clk);
    i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    waitDrain("ignore");
    #1;
    checkOutput("ignore.busyAfterReport", 32'(o_Busy), 32'd0);
    repeat (300) @(negedge i_Clk);
    checkOutput("ignore.stillIdle", 32'(o_Busy), 32'd0);

    // Reset mid-scan: nothing reported, score cleared, next scan runs in full.
    dummy = vecs[0];
    applyStimulus(vecs[0]);
    pulseStart(1'b0, dummy);
    repeat (99) @(negedge i_Clk);
    i_Rst = 1'b0;
    #1;
    checkOutput("rstMid.busy", 32'(o_Busy), 32'd0);
    checkOutput("rstMid.score", 32'(o_Score), 32'd0);
    checkOutput("rstMid.satScore", 32'(satScore), 32'd0);
    checkOutput("rstMid.kill", 32'(o_EnemyKill), 32'd0);
    checkOutput("rstMid.done", 32'(o_Done), 32'd0);
    modelScore    = 0;
    modelSatScore = 0;
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b1;
    repeat (300) @(negedge i_Clk);
    runVector(0);

    // Saturation on the 4000-per-kill instance: two kills then one more.
    runVector(7);
    runVector(0);
    checkOutput("sat.hold", 32'(satScore), 32'd4095);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_hit_detector.md
Name: bullet_hit_detector

Overview:
- Consumes the per-frame bullet, enemy and player positions produced by the bullet generation/move stage.
- Detects player-bullet↔enemy and enemy-bullet↔player collisions with a time-multiplexed scan, one pair per clock.
- Reports kill and consume masks back upstream and maintains the score.
- Sits between the bullet/enemy state logic and the game-state/VGA layers.

Parameters:
- MAX_ENEMY, 15, number of enemy slots
- MAX_ENEMY_BULLET, 30, enemy bullet slots (enemies × 2 sets, flattened enemy-major)
- MAX_PLAYER_BULLET, 16, player bullet slots
- BULLET_W / BULLET_H, 6 / 20, bullet box size in pixels
- ENEMY_W / ENEMY_H, 36 / 36, enemy box size
- PLAYER_W / PLAYER_H, 36 / 36, player box size
- SCORE_PER_KILL, 10, score added per kill

Ports:
- i_Clk  in  1  clock
- i_Rst  in  1  asynchronous, active-low reset
- i_Start  in  1  frame-tick pulse; starts a scan
- i_PlayerBulletPos  in  19*MAX_PLAYER_BULLET  packed {X[18:9],Y[8:0]}; slot n at [19n+18:19n]
- i_PlayerBulletValid  in  MAX_PLAYER_BULLET  bullet active
- i_EnemyPos  in  19*MAX_ENEMY  packed enemy positions
- i_EnemyAlive  in  MAX_ENEMY  enemy alive
- i_EnemyBulletPos  in  19*MAX_ENEMY_BULLET  packed enemy bullet positions
- i_EnemyBulletValid  in  MAX_ENEMY_BULLET  enemy bullet active
- i_PlayerPos  in  19  packed player position
- o_EnemyKill  out  MAX_ENEMY  one-cycle kill mask
- o_PlayerBulletHit  out  MAX_PLAYER_BULLET  one-cycle consumed-bullet mask
- o_PlayerHit  out  1  one-cycle player-hit pulse
- o_Score  out  12  accumulated score, saturating
- o_Busy  out  1  scan in progress
- o_Done  out  1  one-cycle scan-complete pulse

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, indices 0, internal masks 0.
- Reset mid-scan aborts the scan with no partial report and clears o_Score.
- Positions: X = bits[18:9], Y = bits[8:0], top-left corner of each box.
- A position of all ones (19'h7FFFF, NONE) never collides, whatever its valid bit.
- Overlap test, strict inequalities, 11-bit unsigned arithmetic (no wrap):
  - ax < bx+BW and bx < ax+AW and ay < by+BH and by < ay+AH.
  - Touching edges do not collide.
- FSM states: IDLE, SCAN_PB, SCAN_EB, REPORT.
- IDLE:
  - On i_Start, snapshot all position, valid and alive inputs into registers.
  - Clear the hit masks, set o_Busy, go to SCAN_PB.
  - i_Start while o_Busy=1 is ignored.
- SCAN_PB:
  - Nested counters b (bullet, outer) and e (enemy, inner); one pair per cycle; MAX_PLAYER_BULLET*MAX_ENEMY cycles (240).
  - Pair (b,e) qualifies if bullet b is valid, not NONE, not yet hit, and enemy e is alive, not yet killed.
  - A qualifying overlap sets killMask[e] and hitMask[b].
  - Each bullet kills at most one enemy, the lowest-index one. Each enemy is killed by at most one bullet, the lowest-index one.
  - After b=15,e=14 → SCAN_EB.
- SCAN_EB:
  - Counter k from 0 to MAX_ENEMY_BULLET-1, one cycle each (30 cycles).
  - A valid, non-NONE enemy bullet overlapping the snapshot player box sets playerHit.
  - → REPORT.
- REPORT (one cycle):
  - o_EnemyKill = killMask, o_PlayerBulletHit = hitMask, o_PlayerHit = playerHit, o_Done = 1.
  - o_Score += popcount(killMask)*SCORE_PER_KILL, saturating at 4095; it updates in this cycle.
  - o_Busy = 0 in REPORT; next state IDLE.
  - i_Start in the REPORT cycle is ignored.
- Latency: i_Start sampled at edge N → o_Done high during cycle N+271.
- Masks are 0 at all times outside REPORT.

Optional Feature:
- Macro: BULLET_HIT_PLAYER_INVULN_EN.
- Defined:
  - SCAN_EB is not built; SCAN_PB goes directly to REPORT.
  - o_PlayerHit is tied 0; latency becomes N+241.
- Undefined: full behaviour as above.

Test Plan:
- Single kill: bullet0 valid at (302,110), enemy7 alive at (302,108), all else invalid, pulse i_Start → at cycle N+271 o_EnemyKill=15'h0080, o_PlayerBulletHit=16'h0001, o_Done=1, o_Score=10; all masks 0 on the next cycle.
- Same enemy, two bullets: bullets 2 and 5 both overlap alive enemy3 → o_EnemyKill=15'h0008, o_PlayerBulletHit=16'h0004, o_Score +10 only.
- Non-colliding cases each give all masks 0:
  - bullet at X=338 vs enemy at X=302 (touching edge);
  - bullet with valid=0;
  - bullet at 19'h7FFFF;
  - enemy with alive=0.
- Player hit: enemy bullet 5 valid at (310,380), player at (302,372) → o_PlayerHit=1 at N+271.
  - With BULLET_HIT_PLAYER_INVULN_EN defined: o_PlayerHit=0 and o_Done at N+241.
- Saturation: SCORE_PER_KILL=4000, two kills in one scan → o_Score=4095; a further scan with one kill → remains 4095.
- Reset/ignore:
  - i_Start again at N+50 → ignored; o_Done occurs only once, at N+271.
  - i_Rst low at N+100 → all outputs 0, o_Busy=0, no o_Done; a new i_Start after release runs a full scan.
